// File: rtl/reset_sequencer.sv
// reset_sequencer: waits for a debounced PLL lock, holds every downstream
// reset for a fixed time, then releases the channels one after another
// (bit 0 first). Lock loss or a software request re-asserts all channels,
// and o_cause records why the last reset happened.
//
// o_state exposes the FSM encoding for debug and checker binding:
//   0 WAIT_LOCK, 1 FILTER, 2 HOLD, 3 RELEASE, 4 RUN.
module reset_sequencer #(
  parameter int NB_COUNT       = 16,
  parameter int N_CHANNELS     = 3,
  parameter int LOCK_FILTER    = 4,
  parameter int HOLD_CYCLES    = 4,
  parameter int STAGGER_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_locked,
  input  logic                  i_sw_reset,
  output logic [N_CHANNELS-1:0] o_reset,
  output logic                  o_ready,
  output logic [1:0]            o_cause,
  output logic [2:0]            o_state
);

  localparam int CH_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  // Terminal values for the equality compares on cnt. Each count parameter
  // fits in NB_COUNT bits, so cnt never wraps before reaching them.
  localparam logic [NB_COUNT-1:0] FILTER_LAST = NB_COUNT'(LOCK_FILTER - 1);
  localparam logic [NB_COUNT-1:0] HOLD_LAST   = NB_COUNT'(HOLD_CYCLES - 1);
  localparam logic [NB_COUNT-1:0] STG_LAST    =
    NB_COUNT'((STAGGER_CYCLES == 0) ? 0 : STAGGER_CYCLES - 1);
  localparam logic [CH_W-1:0]     CH_LAST     = CH_W'(N_CHANNELS - 1);

  localparam logic [N_CHANNELS-1:0] ALL_ONES = {N_CHANNELS{1'b1}};
  localparam logic [N_CHANNELS-1:0] ONE_HOT0 = N_CHANNELS'(1);

  localparam logic [1:0] CAUSE_EXT  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_SW   = 2'd2;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_FILTER    = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [NB_COUNT-1:0]     cnt_q, cnt_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [N_CHANNELS-1:0]   reset_q, reset_d;
  logic                    ready_q, ready_d;
  logic [1:0]              cause_q, cause_d;

  assign o_reset = reset_q;
  assign o_ready = ready_q;
  assign o_cause = cause_q;
  assign o_state = state_q;

  // State and output registers; i_reset low overrides everything.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      ch_q    <= '0;
      reset_q <= ALL_ONES;
      ready_q <= 1'b0;
      cause_q <= CAUSE_EXT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      reset_q <= reset_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and next-output logic. Lock loss is checked before the
  // software request so it wins when both arrive on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    reset_d = reset_q;
    ready_d = ready_q;
    cause_d = cause_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        reset_d = ALL_ONES;
        ready_d = 1'b0;
        if (i_locked) begin
          if (LOCK_FILTER == 1) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            state_d = ST_FILTER;
            cnt_d   = NB_COUNT'(1);
          end
        end
      end

      ST_FILTER: begin
        // Lock has not been accepted yet, so the cause stays as it was.
        if (!i_locked) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == FILTER_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + NB_COUNT'(1);
        end
      end

      ST_HOLD: begin
        if (!i_locked) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          ch_d    = '0;
          reset_d = ALL_ONES;
          ready_d = 1'b0;
          cause_d = CAUSE_LOCK;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          // Entry edge of the release phase clears bit 0 (or every bit when
          // there is no stagger or only one channel).
          if (STAGGER_CYCLES == 0 || N_CHANNELS == 1) begin
            state_d = ST_RUN;
            reset_d = '0;
            ready_d = 1'b1;
            ch_d    = CH_LAST;
          end else begin
            state_d = ST_RELEASE;
            reset_d = reset_q & ~ONE_HOT0;
            ch_d    = CH_W'(1);
          end
        end else begin
          cnt_d = cnt_q + NB_COUNT'(1);
        end
      end

      ST_RELEASE: begin
        if (!i_locked) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          ch_d    = '0;
          reset_d = ALL_ONES;
          ready_d = 1'b0;
          cause_d = CAUSE_LOCK;
        end else if (cnt_q == STG_LAST) begin
          cnt_d   = '0;
          reset_d = reset_q & ~(ONE_HOT0 << ch_q);
          if (ch_q == CH_LAST) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end else begin
          cnt_d = cnt_q + NB_COUNT'(1);
        end
      end

      ST_RUN: begin
        if (!i_locked) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          ch_d    = '0;
          reset_d = ALL_ONES;
          ready_d = 1'b0;
          cause_d = CAUSE_LOCK;
        end else if (i_sw_reset) begin
          // Software reset skips the lock filter and goes straight to HOLD.
          state_d = ST_HOLD;
          cnt_d   = '0;
          ch_d    = '0;
          reset_d = ALL_ONES;
          ready_d = 1'b0;
          cause_d = CAUSE_SW;
        end
      end

      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
        ch_d    = '0;
        reset_d = ALL_ONES;
        ready_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer. The default-parameter instance is driven
// from a per-edge vector table of hand-computed expected outputs; a second
// instance (no stagger, 4 channels, minimal filter/hold) gets a short
// hand-written sequence.
module tb_reset_sequencer;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] S_WAIT = 3'd0;
  localparam logic [2:0] S_HOLD = 3'd2;

  // default-parameter instance
  logic       rst_n, locked, sw;
  logic [2:0] o_reset;
  logic       o_ready;
  logic [1:0] o_cause;
  logic [2:0] o_state;

  reset_sequencer dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_locked   (locked),
    .i_sw_reset (sw),
    .o_reset    (o_reset),
    .o_ready    (o_ready),
    .o_cause    (o_cause),
    .o_state    (o_state)
  );

  // no-stagger instance
  logic       rst2_n, locked2, sw2;
  logic [3:0] o_reset2;
  logic       o_ready2;
  logic [1:0] o_cause2;
  logic [2:0] o_state2;

  reset_sequencer #(
    .NB_COUNT(16), .N_CHANNELS(4), .LOCK_FILTER(1),
    .HOLD_CYCLES(1), .STAGGER_CYCLES(0)
  ) dut2 (
    .i_clk      (clk),
    .i_reset    (rst2_n),
    .i_locked   (locked2),
    .i_sw_reset (sw2),
    .o_reset    (o_reset2),
    .o_ready    (o_ready2),
    .o_cause    (o_cause2),
    .o_state    (o_state2)
  );

  typedef struct {
    logic       rst;
    logic       lk;
    logic       sw;
    logic [2:0] er;
    logic       erdy;
    logic [1:0] ec;
    logic       chk_st;
    logic [2:0] est;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(input int n, input logic rst, input logic lk,
                              input logic sw, input logic [2:0] er,
                              input logic erdy, input logic [1:0] ec,
                              input logic chk_st = 1'b0,
                              input logic [2:0] est = 3'd0);
    vec_t v;
    v.rst = rst; v.lk = lk; v.sw = sw;
    v.er = er; v.erdy = erdy; v.ec = ec;
    v.chk_st = chk_st; v.est = est;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  // driver: apply inputs away from the edge, sample #1 after the edge
  task automatic step1(input logic r, input logic l, input logic s);
    @(negedge clk);
    rst_n = r; locked = l; sw = s;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic r, input logic l, input logic s);
    @(negedge clk);
    rst2_n = r; locked2 = l; sw2 = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check2(input string name, input logic [3:0] er,
                        input logic erdy);
    checks++;
    if (o_reset2 !== er || o_ready2 !== erdy) begin
      failures++;
      $display("FAIL %s: got reset=%b ready=%b, expected reset=%b ready=%b",
               name, o_reset2, o_ready2, er, erdy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; locked = 1'b0; sw = 1'b0;
    rst2_n = 1'b0; locked2 = 1'b0; sw2 = 1'b0;

    // A: reset for 3 edges with lock already high, then the plain sequence.
    add(3, 0, 1, 0, 3'b111, 0, 0, 1, S_WAIT);
    add(7, 1, 1, 0, 3'b111, 0, 0);          // E0 .. E0+6
    add(2, 1, 1, 0, 3'b110, 0, 0);          // E0+7, E0+8
    add(2, 1, 1, 0, 3'b100, 0, 0);          // E0+9, E0+10
    add(2, 1, 1, 0, 3'b000, 1, 0);          // E0+11 and one RUN edge
    // B: single-cycle software reset at t.
    add(1, 1, 1, 1, 3'b111, 0, 2, 1, S_HOLD);
    add(3, 1, 1, 0, 3'b111, 0, 2);
    add(2, 1, 1, 0, 3'b110, 0, 2);          // t+4, t+5
    add(2, 1, 1, 0, 3'b100, 0, 2);          // t+6, t+7
    add(2, 1, 1, 0, 3'b000, 1, 2);          // t+8 and RUN
    // C: software reset held 3 cycles gives exactly one sequence.
    add(3, 1, 1, 1, 3'b111, 0, 2);
    add(1, 1, 1, 0, 3'b111, 0, 2);
    add(2, 1, 1, 0, 3'b110, 0, 2);
    add(2, 1, 1, 0, 3'b100, 0, 2);
    add(4, 1, 1, 0, 3'b000, 1, 2);
    // D: software reset and lock loss on the same edge: lock loss wins.
    add(1, 1, 0, 1, 3'b111, 0, 1, 1, S_WAIT);
    add(1, 1, 0, 0, 3'b111, 0, 1, 1, S_WAIT);
    // E: relock, i_reset low mid-HOLD, then the glitchy lock pattern.
    add(4, 1, 1, 0, 3'b111, 0, 1);          // E0 .. E0+3 (HOLD entered)
    add(1, 1, 1, 0, 3'b111, 0, 1, 1, S_HOLD);
    add(1, 0, 1, 0, 3'b111, 0, 0, 1, S_WAIT);
    add(2, 1, 1, 0, 3'b111, 0, 0);          // glitch E0, E0+1
    add(1, 1, 0, 0, 3'b111, 0, 0, 1, S_WAIT);  // E0+2 low: cause unchanged
    add(7, 1, 1, 0, 3'b111, 0, 0);          // E0+3 .. E0+9
    add(2, 1, 1, 0, 3'b110, 0, 0);          // E0+10, E0+11
    add(2, 1, 1, 0, 3'b100, 0, 0);
    add(1, 1, 1, 0, 3'b000, 1, 0);          // E0+14
    // F: software reset, then lock loss after bit 0 is released.
    add(4, 1, 1, 1, 3'b111, 0, 2);          // sw at t only matters in RUN
    add(1, 1, 1, 0, 3'b110, 0, 2);          // t+4
    add(1, 1, 0, 0, 3'b111, 0, 1, 1, S_WAIT);
    add(7, 1, 1, 0, 3'b111, 0, 1);
    add(2, 1, 1, 0, 3'b110, 0, 1);
    add(2, 1, 1, 0, 3'b100, 0, 1);
    add(2, 1, 1, 0, 3'b000, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step1(vecs[i].rst, vecs[i].lk, vecs[i].sw);
      checks++;
      if (o_reset !== vecs[i].er || o_ready !== vecs[i].erdy ||
          o_cause !== vecs[i].ec) begin
        failures++;
        $display("FAIL vec%0d: got reset=%b ready=%b cause=%0d, expected reset=%b ready=%b cause=%0d",
                 i, o_reset, o_ready, o_cause, vecs[i].er, vecs[i].erdy, vecs[i].ec);
      end
      if (vecs[i].chk_st) begin
        checks++;
        if (o_state !== vecs[i].est) begin
          failures++;
          $display("FAIL vec%0d_state: got %0d, expected %0d", i, o_state, vecs[i].est);
        end
      end
    end

    // No-stagger instance: all four channels fall together at E0+1.
    step2(0, 0, 0);
    step2(0, 1, 0);
    check2("nostag_reset", 4'b1111, 1'b0);
    step2(1, 1, 0);                          // E0: straight to HOLD
    check2("nostag_e0", 4'b1111, 1'b0);
    step2(1, 1, 0);                          // E0+1
    check2("nostag_e1", 4'b0000, 1'b1);
    step2(1, 1, 0);
    check2("nostag_run", 4'b0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
